// File: rtl/sargantana_icache_refill_pkg.sv
// Shared types and geometry for the icache refill engine.
// The line-align helper clears the offset bits of an address.
package sargantana_icache_pkg;

  localparam int unsigned PADDR_WIDTH         = 40;
  localparam int unsigned LINE_WIDTH          = 512;
  localparam int unsigned BEAT_WIDTH          = 128;
  localparam int unsigned N_WAY               = 4;
  localparam int unsigned WAY_W               = $clog2(N_WAY);
  localparam int unsigned N_BEATS             = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned BEAT_IDX_W          = $clog2(N_BEATS);
  localparam int unsigned ICACHE_OFFSET_WIDTH = 6;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    COLLECT,
    DRAIN,
    RESP
  } refill_state_t;

  function automatic logic [PADDR_WIDTH-1:0] line_align(input logic [PADDR_WIDTH-1:0] addr);
    return {addr[PADDR_WIDTH-1:ICACHE_OFFSET_WIDTH], {ICACHE_OFFSET_WIDTH{1'b0}}};
  endfunction

endpackage

// File: rtl/sargantana_icache_refill_if.sv
// Bundle of icache request, L2 and ifill response signals around the refill engine.
// Signal suffixes are from the engine's point of view.
interface sargantana_icache_refill_if;
  import sargantana_icache_pkg::*;

  logic                    req_valid_i;
  logic [PADDR_WIDTH-1:0]  req_paddr_i;
  logic [WAY_W-1:0]        req_way_i;
  logic                    req_ready_o;
  logic                    l2_req_valid_o;
  logic [PADDR_WIDTH-1:0]  l2_req_paddr_o;
  logic                    l2_req_ready_i;
  logic                    l2_resp_valid_i;
  logic [BEAT_IDX_W-1:0]   l2_resp_beat_i;
  logic [BEAT_WIDTH-1:0]   l2_resp_data_i;
  logic                    l2_inv_valid_i;
  logic [PADDR_WIDTH-1:0]  l2_inv_paddr_i;
  logic                    l2_inv_ready_o;
  logic                    ifill_resp_valid_o;
  logic [LINE_WIDTH-1:0]   ifill_resp_data_o;
  logic [WAY_W-1:0]        ifill_resp_way_o;
  logic                    ifill_resp_inv_valid_o;
  logic [PADDR_WIDTH-1:0]  ifill_resp_inv_paddr_o;
  logic                    busy_o;

  modport slave (
    input  req_valid_i, req_paddr_i, req_way_i, l2_req_ready_i, l2_resp_valid_i,
           l2_resp_beat_i, l2_resp_data_i, l2_inv_valid_i, l2_inv_paddr_i,
    output req_ready_o, l2_req_valid_o, l2_req_paddr_o, l2_inv_ready_o, ifill_resp_valid_o,
           ifill_resp_data_o, ifill_resp_way_o, ifill_resp_inv_valid_o,
           ifill_resp_inv_paddr_o, busy_o
  );

  modport master (
    output req_valid_i, req_paddr_i, req_way_i, l2_req_ready_i, l2_resp_valid_i,
           l2_resp_beat_i, l2_resp_data_i, l2_inv_valid_i, l2_inv_paddr_i,
    input  req_ready_o, l2_req_valid_o, l2_req_paddr_o, l2_inv_ready_o, ifill_resp_valid_o,
           ifill_resp_data_o, ifill_resp_way_o, ifill_resp_inv_valid_o,
           ifill_resp_inv_paddr_o, busy_o
  );

endinterface

// File: rtl/sargantana_icache_line_buffer.sv
// Beat-indexed line assembly buffer with a per-beat completion mask.
// full_o reports that the mask is all-ones once the current write lands.
module sargantana_icache_line_buffer
  import sargantana_icache_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  clear_i,
  input  logic                  write_i,
  input  logic [BEAT_IDX_W-1:0] beat_i,
  input  logic [BEAT_WIDTH-1:0] data_i,
  output logic                  full_o,
  output logic [LINE_WIDTH-1:0] line_o
);

  logic [N_BEATS-1:0]    r_mask;
  logic [N_BEATS-1:0]    w_mask_d;
  logic [LINE_WIDTH-1:0] r_line;

  always_comb begin
    w_mask_d = r_mask;
    if (clear_i) w_mask_d = '0;
    if (write_i) w_mask_d[beat_i] = 1'b1;
  end

  assign full_o = &w_mask_d;
  assign line_o = r_line;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_mask <= '0;
      r_line <= '0;
    end else begin
      r_mask <= w_mask_d;
      if (write_i) r_line[beat_i*BEAT_WIDTH +: BEAT_WIDTH] <= data_i;
    end
  end

endmodule

// File: rtl/sargantana_icache_refill.sv
// Icache refill engine: one line-aligned L2 read, beat gathering, single-cycle ifill
// response, plus forwarding of L2 invalidations onto the same response channel.
module sargantana_icache_refill
  import sargantana_icache_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       kill_i,
  sargantana_icache_refill_if.slave  bus
);

  refill_state_t          r_state, w_state_d;
  logic [PADDR_WIDTH-1:0] r_paddr;
  logic [WAY_W-1:0]       r_way;
  logic                   r_inv_valid;
  logic [PADDR_WIDTH-1:0] r_inv_paddr;
  logic                   w_clear;
  logic                   w_write;
  logic                   w_full;
  logic                   w_inv_ready;
  logic [LINE_WIDTH-1:0]  w_line;

  // Drained beats still update the mask so the engine knows when L2 is done.
  assign w_write = bus.l2_resp_valid_i && (r_state == COLLECT || r_state == DRAIN);

  sargantana_icache_line_buffer u_line_buffer (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .clear_i (w_clear),
    .write_i (w_write),
    .beat_i  (bus.l2_resp_beat_i),
    .data_i  (bus.l2_resp_data_i),
    .full_o  (w_full),
    .line_o  (w_line)
  );

  always_comb begin
    w_state_d = r_state;
    w_clear   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.req_valid_i && !kill_i) begin
          w_state_d = REQ;
          w_clear   = 1'b1;
        end
      end
      REQ: begin
        if (bus.l2_req_ready_i) w_state_d = kill_i ? DRAIN : COLLECT;
        else if (kill_i)        w_state_d = IDLE;
      end
      COLLECT: begin
        if (w_write && w_full) w_state_d = kill_i ? IDLE : RESP;
        else if (kill_i)       w_state_d = DRAIN;
      end
      DRAIN: begin
        if (w_write && w_full) w_state_d = IDLE;
      end
      RESP:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  // Refuse invalidations whenever a refill response owns the channel this or next cycle.
  assign w_inv_ready = bus.l2_inv_valid_i && (r_state != RESP) && (w_state_d != RESP);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state     <= IDLE;
      r_paddr     <= '0;
      r_way       <= '0;
      r_inv_valid <= 1'b0;
      r_inv_paddr <= '0;
    end else begin
      r_state     <= w_state_d;
      r_inv_valid <= w_inv_ready;
      if (w_clear) begin
        r_paddr <= line_align(bus.req_paddr_i);
        r_way   <= bus.req_way_i;
      end
      if (w_inv_ready) r_inv_paddr <= line_align(bus.l2_inv_paddr_i);
    end
  end

  assign bus.req_ready_o            = (r_state == IDLE);
  assign bus.busy_o                 = (r_state != IDLE);
  assign bus.l2_req_valid_o         = (r_state == REQ);
  assign bus.l2_req_paddr_o         = r_paddr;
  assign bus.l2_inv_ready_o         = w_inv_ready;
  assign bus.ifill_resp_valid_o     = (r_state == RESP) || r_inv_valid;
  assign bus.ifill_resp_inv_valid_o = r_inv_valid;
  assign bus.ifill_resp_inv_paddr_o = r_inv_paddr;
  assign bus.ifill_resp_data_o      = w_line;
  assign bus.ifill_resp_way_o       = r_way;

endmodule

// File: tb/tb_sargantana_icache_refill.sv
// Directed bench for the icache refill engine: refill, reordering, kills,
// invalidation arbitration and mid-refill reset.
module tb_sargantana_icache_refill;
  import sargantana_icache_pkg::*;

  logic clk;
  logic rstn;
  logic kill;
  int   total;
  int   bad;

  sargantana_icache_refill_if bus ();

  sargantana_icache_refill dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .kill_i (kill),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Present one beat for one cycle; no refill response may be visible while it is presented.
  task automatic beat(input logic [1:0] idx, input logic [127:0] data, input string tag);
    bus.l2_resp_valid_i = 1'b1;
    bus.l2_resp_beat_i  = idx;
    bus.l2_resp_data_i  = data;
    settle();
    chk(tag, bus.ifill_resp_valid_o, 1'b0);
    nxt();
    bus.l2_resp_valid_i = 1'b0;
  endtask

  // Issue a request and grant it on the first REQ cycle; leaves the engine in COLLECT.
  task automatic do_req(input logic [39:0] paddr, input logic [1:0] way, input logic [39:0] exp_pa,
                        input string tag);
    bus.req_valid_i = 1'b1;
    bus.req_paddr_i = paddr;
    bus.req_way_i   = way;
    nxt();
    bus.req_valid_i    = 1'b0;
    bus.l2_req_ready_i = 1'b1;
    settle();
    chk({tag, "_l2_paddr"}, bus.l2_req_paddr_o, exp_pa);
    nxt();
    bus.l2_req_ready_i = 1'b0;
  endtask

  logic [511:0] exp_line;
  logic [127:0] fill [4];

  initial begin
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    kill  = 1'b0;
    bus.req_valid_i     = 1'b0;
    bus.req_paddr_i     = '0;
    bus.req_way_i       = '0;
    bus.l2_req_ready_i  = 1'b0;
    bus.l2_resp_valid_i = 1'b0;
    bus.l2_resp_beat_i  = '0;
    bus.l2_resp_data_i  = '0;
    bus.l2_inv_valid_i  = 1'b0;
    bus.l2_inv_paddr_i  = '0;
    nxt();
    nxt();
    settle();
    chk("rst_req_ready", bus.req_ready_o, 1'b1);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_l2_valid", bus.l2_req_valid_o, 1'b0);
    chk("rst_resp_valid", bus.ifill_resp_valid_o, 1'b0);
    chk("rst_data", bus.ifill_resp_data_o, 512'h0);
    rstn = 1'b1;
    nxt();

    // Basic refill, L2 accepts on the third REQ cycle
    bus.req_valid_i = 1'b1;
    bus.req_paddr_i = 40'h80001234;
    bus.req_way_i   = 2'd2;
    settle();
    chk("basic_req_ready", bus.req_ready_o, 1'b1);
    nxt();
    bus.req_valid_i = 1'b0;
    settle();
    chk("basic_l2_valid", bus.l2_req_valid_o, 1'b1);
    chk("basic_l2_paddr", bus.l2_req_paddr_o, 40'h80001200);
    chk("basic_busy", bus.busy_o, 1'b1);
    chk("basic_req_ready_busy", bus.req_ready_o, 1'b0);
    nxt();
    settle();
    chk("basic_l2_hold", bus.l2_req_valid_o, 1'b1);
    nxt();
    bus.l2_req_ready_i = 1'b1;
    settle();
    chk("basic_l2_hold_paddr", bus.l2_req_paddr_o, 40'h80001200);
    nxt();
    bus.l2_req_ready_i = 1'b0;
    settle();
    chk("basic_l2_dropped", bus.l2_req_valid_o, 1'b0);
    fill[0] = {32{4'hA}};
    fill[1] = {32{4'hB}};
    fill[2] = {32{4'hC}};
    fill[3] = {32{4'hD}};
    for (int i = 0; i < 4; i++) beat(2'(i), fill[i], "basic_no_early_resp");
    exp_line = {fill[3], fill[2], fill[1], fill[0]};
    settle();
    chk("basic_resp_valid", bus.ifill_resp_valid_o, 1'b1);
    chk("basic_resp_inv", bus.ifill_resp_inv_valid_o, 1'b0);
    chk("basic_resp_data", bus.ifill_resp_data_o, exp_line);
    chk("basic_resp_way", bus.ifill_resp_way_o, 2'd2);
    nxt();
    settle();
    chk("basic_single_pulse", bus.ifill_resp_valid_o, 1'b0);
    chk("basic_idle", bus.req_ready_o, 1'b1);

    // Out-of-order beats 2,0,2(duplicate),3,1
    do_req(40'h1000007F, 2'd1, 40'h10000040, "ooo");
    fill[0] = {4{32'hC0DE0000}};
    fill[1] = {4{32'hC0DE0001}};
    fill[2] = {4{32'hC0DE0002}};
    fill[3] = {4{32'hC0DE0003}};
    beat(2'd2, {4{32'hDEADBEEF}}, "ooo_b2");
    beat(2'd0, fill[0], "ooo_b0");
    beat(2'd2, fill[2], "ooo_b2_dup");
    beat(2'd3, fill[3], "ooo_b3");
    settle();
    chk("ooo_dup_not_counted", bus.ifill_resp_valid_o, 1'b0);
    chk("ooo_still_busy", bus.busy_o, 1'b1);
    beat(2'd1, fill[1], "ooo_b1");
    exp_line = {fill[3], fill[2], fill[1], fill[0]};
    settle();
    chk("ooo_resp_valid", bus.ifill_resp_valid_o, 1'b1);
    chk("ooo_resp_data", bus.ifill_resp_data_o, exp_line);
    chk("ooo_resp_way", bus.ifill_resp_way_o, 2'd1);
    nxt();

    // Kill in COLLECT after beat 1, drain, then an immediate new refill
    do_req(40'h20000000, 2'd3, 40'h20000000, "kill_col");
    beat(2'd0, {4{32'h11111111}}, "kill_col_b0");
    beat(2'd1, {4{32'h22222222}}, "kill_col_b1");
    kill = 1'b1;
    nxt();
    kill = 1'b0;
    settle();
    chk("kill_col_drain_busy", bus.busy_o, 1'b1);
    chk("kill_col_drain_not_ready", bus.req_ready_o, 1'b0);
    beat(2'd2, {4{32'h33333333}}, "kill_col_b2");
    settle();
    chk("kill_col_after_b2_not_ready", bus.req_ready_o, 1'b0);
    beat(2'd3, {4{32'h44444444}}, "kill_col_b3");
    settle();
    chk("kill_col_ready_back", bus.req_ready_o, 1'b1);
    chk("kill_col_no_resp", bus.ifill_resp_valid_o, 1'b0);
    do_req(40'h300000BF, 2'd0, 40'h30000080, "after_kill");
    for (int i = 0; i < 4; i++) beat(2'(i), fill[3-i], "after_kill_beat");
    exp_line = {fill[0], fill[1], fill[2], fill[3]};
    settle();
    chk("after_kill_resp_valid", bus.ifill_resp_valid_o, 1'b1);
    chk("after_kill_resp_data", bus.ifill_resp_data_o, exp_line);
    chk("after_kill_resp_way", bus.ifill_resp_way_o, 2'd0);
    nxt();

    // Kill in REQ before the handshake, then kill dropping a fresh request
    bus.req_valid_i = 1'b1;
    bus.req_paddr_i = 40'h60000000;
    nxt();
    bus.req_valid_i = 1'b0;
    kill = 1'b1;
    settle();
    chk("kill_req_l2_valid", bus.l2_req_valid_o, 1'b1);
    nxt();
    kill = 1'b0;
    settle();
    chk("kill_req_idle", bus.busy_o, 1'b0);
    chk("kill_req_l2_dropped", bus.l2_req_valid_o, 1'b0);
    beat(2'd0, {4{32'h55555555}}, "kill_req_stray");
    settle();
    chk("kill_req_stray_busy", bus.busy_o, 1'b0);
    bus.req_valid_i = 1'b1;
    kill = 1'b1;
    nxt();
    bus.req_valid_i = 1'b0;
    kill = 1'b0;
    settle();
    chk("kill_same_cycle_dropped", bus.busy_o, 1'b0);

    // Invalidation colliding with the RESP cycle
    do_req(40'h40000000, 2'd1, 40'h40000000, "inv");
    for (int i = 0; i < 4; i++) beat(2'(i), fill[i], "inv_beat");
    bus.l2_inv_valid_i = 1'b1;
    bus.l2_inv_paddr_i = 40'h80004040;
    settle();
    chk("inv_refill_first", bus.ifill_resp_valid_o, 1'b1);
    chk("inv_refill_not_inv", bus.ifill_resp_inv_valid_o, 1'b0);
    chk("inv_ready_blocked", bus.l2_inv_ready_o, 1'b0);
    nxt();
    settle();
    chk("inv_ready_now", bus.l2_inv_ready_o, 1'b1);
    chk("inv_gap", bus.ifill_resp_valid_o, 1'b0);
    nxt();
    bus.l2_inv_valid_i = 1'b0;
    settle();
    chk("inv_resp_valid", bus.ifill_resp_valid_o, 1'b1);
    chk("inv_resp_inv", bus.ifill_resp_inv_valid_o, 1'b1);
    chk("inv_resp_paddr", bus.ifill_resp_inv_paddr_o, 40'h80004040);
    nxt();
    bus.l2_inv_valid_i = 1'b1;
    bus.l2_inv_paddr_i = 40'h123456789F;
    settle();
    chk("inv2_ready", bus.l2_inv_ready_o, 1'b1);
    nxt();
    bus.l2_inv_valid_i = 1'b0;
    settle();
    chk("inv2_paddr_aligned", bus.ifill_resp_inv_paddr_o, 40'h1234567880);
    nxt();

    // Reset after beat 2 discards the partial line
    do_req(40'h50000000, 2'd2, 40'h50000000, "rst_mid");
    for (int i = 0; i < 3; i++) beat(2'(i), fill[i], "rst_mid_beat");
    rstn = 1'b0;
    nxt();
    rstn = 1'b1;
    settle();
    chk("rst_mid_ready", bus.req_ready_o, 1'b1);
    chk("rst_mid_busy", bus.busy_o, 1'b0);
    chk("rst_mid_l2_paddr", bus.l2_req_paddr_o, 40'h0);
    chk("rst_mid_way", bus.ifill_resp_way_o, 2'd0);
    chk("rst_mid_data", bus.ifill_resp_data_o, 512'h0);
    chk("rst_mid_inv_paddr", bus.ifill_resp_inv_paddr_o, 40'h0);
    beat(2'd3, fill[3], "rst_mid_trailing");
    settle();
    chk("rst_mid_trailing_busy", bus.busy_o, 1'b0);
    chk("rst_mid_trailing_no_resp", bus.ifill_resp_valid_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sargantana_icache_refill.md
Name: sargantana_icache_refill

Overview:
Refill engine directly upstream of the instruction cache top level. It accepts the single-line ifill request from the icache, issues a line-aligned read to L2, and gathers the BEAT_WIDTH-wide response beats into one full cache line. It returns that line to the icache as a single-cycle ifill response. It also forwards L2 invalidations onto the same response channel and absorbs beats from refills the core has killed.

Parameters:
PADDR_WIDTH, 40, physical address width
LINE_WIDTH, 512, cache-line width in bits (64 B line, 6 offset bits)
BEAT_WIDTH, 128, L2 response beat width; N_BEATS = LINE_WIDTH/BEAT_WIDTH = 4
N_WAY, 4, icache ways; WAY_W = $clog2(N_WAY)

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset; synchronous, active-low
kill_i  in  1  core kill of the in-flight fetch
req_valid_i  in  1  ifill request from icache
req_paddr_i  in  PADDR_WIDTH  request address; low 6 bits ignored
req_way_i  in  WAY_W  victim way chosen by the icache
req_ready_o  out  1  engine idle, request accepted
l2_req_valid_o  out  1  read request to L2
l2_req_paddr_o  out  PADDR_WIDTH  line-aligned address; bits [5:0] are 0
l2_req_ready_i  in  1  L2 accepts request
l2_resp_valid_i  in  1  data beat valid
l2_resp_beat_i  in  2  beat index
l2_resp_data_i  in  BEAT_WIDTH  beat data
l2_inv_valid_i  in  1  L2 invalidation request
l2_inv_paddr_i  in  PADDR_WIDTH  line to invalidate
l2_inv_ready_o  out  1  invalidation consumed this cycle
ifill_resp_valid_o  out  1  response pulse to icache
ifill_resp_data_o  out  LINE_WIDTH  assembled line
ifill_resp_way_o  out  WAY_W  way latched with the request
ifill_resp_inv_valid_o  out  1  response is an invalidation
ifill_resp_inv_paddr_o  out  PADDR_WIDTH  invalidated line address
busy_o  out  1  state != IDLE

Behaviour:
- All state and registered outputs update on posedge clk_i. With rstn_i=0 at a clock edge:
  - state goes to IDLE and the beat mask clears;
  - all valid outputs go to 0, data/addr/way go to 0, req_ready_o goes to 1.
- Reset mid-refill discards the partial line. Beats arriving after reset is released are ignored in IDLE.
- FSM states and transitions:
  - IDLE: req_ready_o=1. On req_valid_i && !kill_i, latch paddr (aligned) and way, then go to REQ. A request with kill_i high in the same cycle is dropped.
  - REQ: l2_req_valid_o=1 and held stable until l2_req_ready_i.
    - kill_i before the handshake returns to IDLE; no request is counted as sent.
    - Handshake together with kill_i goes to DRAIN.
    - Handshake alone goes to COLLECT.
  - COLLECT: each l2_resp_valid_i writes l2_resp_data_i into slice [beat*BEAT_WIDTH +: BEAT_WIDTH] and sets mask bit [beat].
    - When the mask becomes all-ones, go to RESP.
    - kill_i at any time, including the cycle of the final beat, goes to DRAIN, or to IDLE if that beat completed the line.
    - A duplicate beat index overwrites its slice and is not double-counted.
  - DRAIN: beats are absorbed without driving a response. Return to IDLE once all 4 beats are seen.
  - RESP: one cycle with ifill_resp_valid_o=1, inv_valid_o=0, data and way driven; then go to IDLE. kill_i in RESP does not suppress the pulse; the icache gates it.
- Invalidation forwarding is combinational-to-registered with 1 cycle of latency:
  - In any state except RESP, l2_inv_valid_i gives l2_inv_ready_o=1.
  - The next cycle then drives ifill_resp_valid_o=1, ifill_resp_inv_valid_o=1, inv_paddr=l2_inv_paddr_i & ~6'h3F.
  - In RESP, or when the registered response slot holds a pending refill response, l2_inv_ready_o=0 and L2 must hold the invalidation. A refill response always beats an invalidation.
- Invalidation forwarding does not disturb the FSM. An invalidation of the in-flight line still completes the refill; the icache writes and the next access re-checks.
- ifill_resp_valid_o is never high for 2 consecutive cycles from the same refill.
- busy_o = (state != IDLE).

Decomposition:
- Package sargantana_icache_pkg holds:
  - the refill_state_t enum {IDLE, REQ, COLLECT, DRAIN, RESP};
  - localparams N_BEATS, ICACHE_OFFSET_WIDTH=6, and the beat-index width.
- One natural sub-module, sargantana_icache_line_buffer: the beat-indexed write buffer with the completion mask. It exposes clear, write, beat, data, full, and line.
- The FSM and invalidation arbitration stay in the top level.

Test Plan:
- Basic refill: request paddr 0x80001234 with way 2; L2 accepts after 3 cycles; beats 0..3 in order carry 0xA..0xD fills. Expect l2_req_paddr_o=0x80001200, then a single ifill_resp_valid_o pulse 1 cycle after beat 3, with data {D,C,B,A} and way 2.
- Out-of-order beats: beats arrive 2,0,3,1. The line is assembled by index and the response pulses only after the 4th beat.
- Kill in COLLECT after beat 1: no ifill response. Beats 2 and 3 are absorbed. req_ready_o returns to 1 the cycle after beat 3. An immediate new request goes out correctly.
- Kill in REQ before l2_req_ready_i: returns to IDLE, no L2 handshake. Late L2 traffic never arrives and no response is produced.
- Invalidation 0x80004040 in the same cycle as the RESP cycle of a refill:
  - refill response first, with l2_inv_ready_o=0;
  - next cycle l2_inv_ready_o=1;
  - following cycle inv_valid=1 with inv_paddr=0x80004040.
- Reset asserted after beat 2: all outputs go to their reset values next edge. Trailing beat 3 is ignored and busy_o=0.
